// File: rtl/sc_dec_bi_acc.sv
// ============================================================================
// Module   : sc_dec_bi_acc
// Brief    : Bipolar stochastic-to-binary decoder, 2^WIDTH-bit window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_dec_bi_acc #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iStart,
    input  logic               iCont,
    input  logic               iEn,
    input  logic               iBit,
    output logic               oBusy,
    output logic               oValid,
    output logic [WIDTH+1:0]   oValue,
    output logic [WIDTH:0]     oOnes
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH:0]   c_last = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH+1:0] c_n    = {2'b01, {WIDTH{1'b0}}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH:0]     r_cnt;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH:0]     w_cnt_nxt;
    logic [WIDTH:0]     w_acc_nxt;
    logic [WIDTH:0]     w_ones;
    logic [WIDTH+1:0]   w_value;
    logic               w_last;

    assign w_last  = (r_state == RUN) && iEn && (r_cnt == c_last);
    assign w_ones  = r_acc + {{WIDTH{1'b0}}, iBit};
    // 2*ones - N; the WIDTH+2 result covers -N..+N without saturation
    assign w_value = {w_ones, 1'b0} - c_n;
    assign oBusy   = (r_state == RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        case (r_state)
            IDLE: begin
                if (iStart) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = '0;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_state_nxt = iCont ? RUN : IDLE;
                end else if (iEn) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_acc_nxt = w_ones;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // Results persist until the next completed window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oValid <= 1'b0;
            oValue <= '0;
            oOnes  <= '0;
        end else begin
            oValid <= w_last;
            if (w_last) begin
                oValue <= w_value;
                oOnes  <= w_ones;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sc_dec_bi_acc.sv
// ============================================================================
// Module   : tb_sc_dec_bi_acc
// Brief    : Directed self-checking bench for sc_dec_bi_acc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_dec_bi_acc;

    localparam int N  = 256;
    localparam int N4 = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iStart = 1'b0, iCont = 1'b0, iEn = 1'b0, iBit = 1'b0;
    logic        oBusy, oValid;
    logic [9:0]  oValue;
    logic [8:0]  oOnes;

    logic        start4 = 1'b0, en4 = 1'b0, bit4 = 1'b0;
    logic        busy4, valid4;
    logic [5:0]  value4;
    logic [4:0]  ones4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcyc[$];

    sc_dec_bi_acc #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .iStart(iStart), .iCont(iCont), .iEn(iEn),
        .iBit(iBit), .oBusy(oBusy), .oValid(oValid), .oValue(oValue), .oOnes(oOnes)
    );

    sc_dec_bi_acc #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .iStart(start4), .iCont(1'b0), .iEn(en4),
        .iBit(bit4), .oBusy(busy4), .oValid(valid4), .oValue(value4), .oOnes(ones4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic pat(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (i % 2 == 0);
            default: return (i < 192);
        endcase
    endfunction

    task automatic do_start();
        iStart = 1'b1;
        @(posedge clk); #1;
        iStart = 1'b0;
    endtask

    // One full window of N valid bits; iStart pokes during RUN must be ignored
    task automatic run_window(input int mode, input logic cont, input logic start_last,
                              input int exp_ones, input int exp_val, input string tag);
        int early;
        early = 0;
        iCont = cont;
        for (int i = 0; i < N; i++) begin
            iEn    = 1'b1;
            iBit   = pat(mode, i);
            iStart = (i == 50) || (start_last && i == N - 1);
            @(posedge clk); #1;
            if (i < N - 1) early += int'(oValid);
        end
        iEn = 1'b0; iBit = 1'b0; iStart = 1'b0;
        vcyc.push_back(cyc);
        chk({tag, "_early_valid"}, early, 0);
        chk({tag, "_valid"}, int'(oValid), 1);
        chk({tag, "_ones"}, int'(oOnes), exp_ones);
        chk({tag, "_value"}, int'($signed(oValue)), exp_val);
        chk({tag, "_busy"}, int'(oBusy), int'(cont));
    endtask

    initial begin
        int early;
        logic [15:0] xin;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_value", int'(oValue), 0);
        chk("rst_ones", int'(oOnes), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_start();
        chk("start_busy", int'(oBusy), 1);
        run_window(0, 1'b0, 1'b0, 256, 256, "ones");
        @(posedge clk); #1;
        chk("ones_pulse_end", int'(oValid), 0);
        chk("ones_idle", int'(oBusy), 0);
        chk("ones_hold", int'($signed(oValue)), 256);

        do_start();
        run_window(1, 1'b0, 1'b0, 0, -256, "zeros");
        do_start();
        run_window(2, 1'b0, 1'b0, 128, 0, "alt");
        do_start();
        run_window(3, 1'b0, 1'b0, 192, 128, "p192");

        // Mid-window asynchronous reset
        do_start();
        for (int i = 0; i < 100; i++) begin
            iEn = 1'b1; iBit = 1'b1;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(oBusy), 0);
        chk("arst_value", int'(oValue), 0);
        chk("arst_ones", int'(oOnes), 0);
        chk("arst_valid", int'(oValid), 0);
        iEn = 1'b0; iBit = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle", int'(oBusy), 0);
        do_start();
        run_window(2, 1'b0, 1'b0, 128, 0, "post_rst");

        // Stall on every other cycle, forced iBit=0 on stall cycles
        do_start();
        early = 0;
        for (int k = 0; k < 511; k++) begin
            iEn  = (k % 2 == 0);
            iBit = (k % 2 == 0);
            @(posedge clk); #1;
            if (k < 510) early += int'(oValid);
        end
        iEn = 1'b0; iBit = 1'b0;
        chk("stall_early_valid", early, 0);
        chk("stall_valid", int'(oValid), 1);
        chk("stall_value", int'($signed(oValue)), 256);

        // Continuous mode, three back-to-back windows
        vcyc.delete();
        do_start();
        run_window(0, 1'b1, 1'b0, 256, 256, "cont1");
        run_window(1, 1'b1, 1'b0, 0, -256, "cont2");
        run_window(2, 1'b0, 1'b1, 128, 0, "cont3");
        chk("cont_period12", vcyc[1] - vcyc[0], N);
        chk("cont_period23", vcyc[2] - vcyc[1], N);
        @(posedge clk); #1;
        chk("cont_last_start_ignored", int'(oBusy), 0);

        // WIDTH=4: 16-input mux-add of constant bipolar inputs, select = cycle index
        for (int t = 0; t < 3; t++) begin
            int exp_v;
            xin   = (t == 0) ? 16'hFFF0 : (t == 1) ? 16'h0001 : 16'hA5C3;
            exp_v = (t == 0) ? 8 : (t == 1) ? -14 : 0;
            start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
            for (int i = 0; i < N4; i++) begin
                en4  = 1'b1;
                bit4 = xin[i];
                @(posedge clk); #1;
            end
            en4 = 1'b0; bit4 = 1'b0;
            chk("w4_valid", int'(valid4), 1);
            chk("w4_value", int'($signed(value4)), exp_v);
            chk("w4_range", int'($signed(value4) >= -16 && $signed(value4) <= 16), 1);
            @(posedge clk); #1;
            chk("w4_idle", int'(busy4), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
